video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter CW, default 8: bits per colour channel.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 Parameters HS_POL/VS_POL, default 0/0: asserted sync level; 0 means active-low.
REQ-005 Parameter CHECK_LOG2, default 5: checker square edge = 2^CHECK_LOG2 pixels.
REQ-006 CLK  in  1  pixel clock; all logic is in this single domain.
REQ-007 RST_N  in  1  synchronous, active-low reset.
REQ-008 MODE  in  2  pattern select: 0 gradation, 1 colour bars, 2 checker, 3 solid.
REQ-009 SOLID_RGB  in  3*CW  solid colour {R,G,B} for mode 3.
REQ-010 VGA_R/VGA_G/VGA_B  out  CW each  pixel colour.
REQ-011 VGA_HS/VGA_VS/VGA_DE  out  1 each  syncs and data enable.
REQ-012 FRAME_START  out  1  one-cycle pulse with the first active pixel of each frame.

Function
REQ-013 h counts 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters) and wraps to 0; v increments on each h wrap and counts 0..V_TOTAL-1, wrapping to 0.
REQ-014 DE = (h < H_ACTIVE) and (v < V_ACTIVE).
REQ-015 HS = HS_POL for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else not HS_POL.
REQ-016 VS = VS_POL for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for whole lines, else not VS_POL.
REQ-017 All outputs are registered, exactly 1 cycle after the counter state they describe, and mutually aligned.
REQ-018 The active mode is latched from MODE only at h=0, v=0; MODE changes mid-frame take effect at the next frame.
REQ-019 SOLID_RGB is sampled every cycle; it is not latched per frame.
REQ-020 Gradation: R=G=B=(h+offset) mod 2^CW; offset is 0 unless REQ-028 applies.
REQ-021 Colour bars: BAR_W = H_ACTIVE/8 (elaboration-time integer division), bar index = h/BAR_W saturated at 7; colours white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones.
REQ-022 Checker: white when h[CHECK_LOG2] xor v[CHECK_LOG2] = 0, else black.
REQ-023 Solid: R,G,B = SOLID_RGB fields.
REQ-024 R, G and B are 0 whenever DE is 0.
REQ-025 FRAME_START = 1 exactly on the output cycle carrying h=0, v=0.

Reset
REQ-026 While RST_N is 0 at a CLK edge: h=v=0; RGB=0; DE=0; FRAME_START=0; HS = not HS_POL; VS = not VS_POL; mode = gradation; offset = 0.
REQ-027 Reset asserted mid-frame aborts the frame; the first cycle after release presents counter state h=0, v=0 on the following edge, so FRAME_START pulses on the 2nd cycle after release.

Configuration
REQ-028 With VIDEO_PATTERN_GEN_SCROLL_EN defined, offset (CW bits) increments by 1 at each v wrap, mod 2^CW, so the gradation scrolls one pixel per frame.
REQ-029 With VIDEO_PATTERN_GEN_SCROLL_EN undefined, the offset register does not exist and offset is constant 0.

Structure
REQ-030 Package video_pattern_pkg holds the pattern-mode enum (PAT_GRAD, PAT_BARS, PAT_CHECK, PAT_SOLID) and the 8-entry bar colour table.
REQ-031 Sub-module video_timing_gen contains the h/v counters and the raw HS/VS/DE decode; video_pattern_gen adds pattern selection and the output register stage.

Verification
All scenarios use test parameters H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8), CW=8, CHECK_LOG2=2.

REQ-032 Reset release, MODE=0:
- DE high for 16 of every 24 cycles.
- HS low at h=18..20.
- VS low for 48 cycles (lines 5..6).
- FRAME_START every 192 cycles.
- The first active line reads 0,1,..,15.

REQ-033 MODE=1: per-pixel RGB on active pixels 0..15 = white,white,yellow,yellow,...,black,black (BAR_W=2).

REQ-034 MODE=2: line 0 pixels 0-3 white, 4-7 black; line 4 is not active; line 3 equals line 0 pattern shifted per v[2]=0.

REQ-035 MODE switched 0 -> 3 with SOLID_RGB=0x123456 at h=5, v=2: the rest of the current frame remains gradation; the next frame reads R=0x12, G=0x34, B=0x56 on active pixels and 0 elsewhere.

REQ-036 RST_N pulled low for 3 cycles mid-line at v=2: outputs take their reset values; FRAME_START pulses 2 cycles after release.

REQ-037 With VIDEO_PATTERN_GEN_SCROLL_EN defined: the first pixel of frames 0, 1 and 2 reads 0, 1 and 2; after 256 frames it reads 0 again.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the video pattern generator:
// pattern-mode encoding and the colour-bar table.
package video_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_GRAD  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_e;

    // One {R,G,B} on/off triple per bar, index 0 = leftmost bar.
    // Order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: free-running h/v counters and combinational
// decode of the raw DE/HS/VS levels for the current counter state.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic          frame_first,
    output logic          frame_last
);

    // Inclusive bounds so a window ending exactly at the total still fits the counter width.
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HA_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] VA_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Next counter state: h wraps at end of line, v advances on each h wrap.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    // Counter registers; reset restarts the raster at the top-left pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Raw decode of the current counter state (registered by the parent).
    always_comb begin
        de          = (h_q <= HA_LAST) && (v_q <= VA_LAST);
        hs          = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : !HS_POL;
        vs          = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : !VS_POL;
        frame_first = (h_q == '0) && (v_q == '0);
        frame_last  = (h_q == H_LAST) && (v_q == V_LAST);
    end

    assign h = h_q;
    assign v = v_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: timing from video_timing_gen, per-pixel
// pattern selection, and one output register stage aligning all outputs.
// Optional: define VIDEO_PATTERN_GEN_SCROLL_EN to scroll the gradation
// by one pixel per frame.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int CW         = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CHECK_LOG2 = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      MODE,
    input  logic [3*CW-1:0] SOLID_RGB,
    output logic [CW-1:0]   VGA_R,
    output logic [CW-1:0]   VGA_G,
    output logic [CW-1:0]   VGA_B,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic            VGA_DE,
    output logic            FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Guard against a zero divisor for very narrow active widths.
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [HW-1:0] tg_h;
    logic [VW-1:0] tg_v;
    logic          tg_de, tg_hs, tg_vs, tg_first, tg_last;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_timing (
        .clk         (CLK),
        .rst_n       (RST_N),
        .h           (tg_h),
        .v           (tg_v),
        .de          (tg_de),
        .hs          (tg_hs),
        .vs          (tg_vs),
        .frame_first (tg_first),
        .frame_last  (tg_last)
    );

    pat_mode_e mode_q, mode_d, mode_cur;

    // The frame's mode is taken from MODE at the top-left pixel, and that pixel
    // already uses it; every other pixel uses the latched value.
    always_comb begin
        mode_cur = tg_first ? pat_mode_e'(MODE) : mode_q;
        mode_d   = mode_cur;
    end

    // Frame mode register.
    always_ff @(posedge CLK) begin
        if (!RST_N) mode_q <= PAT_GRAD;
        else        mode_q <= mode_d;
    end

    logic [CW-1:0] offset;

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
    logic [CW-1:0] offset_q, offset_d;

    // Gradation offset advances once per frame, on the last raster position.
    always_comb begin
        offset_d = tg_last ? offset_q + CW'(1) : offset_q;
    end

    // Scroll offset register.
    always_ff @(posedge CLK) begin
        if (!RST_N) offset_q <= '0;
        else        offset_q <= offset_d;
    end

    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    logic [31:0]   bar_idx;
    logic [2:0]    bar_sel;
    logic [2:0]    bar_rgb;
    logic          chk_black;
    logic [CW-1:0] pix_r, pix_g, pix_b;

    // Pattern colour for the current counter state; blanked outside DE.
    always_comb begin
        bar_idx   = 32'(tg_h) / BAR_W;
        bar_sel   = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
        bar_rgb   = bar_colour(bar_sel);
        chk_black = ((((32'(tg_h) ^ 32'(tg_v)) >> CHECK_LOG2) & 32'd1) != 32'd0);
        pix_r     = '0;
        pix_g     = '0;
        pix_b     = '0;
        case (mode_cur)
            PAT_GRAD: begin
                pix_r = CW'(tg_h) + offset;
                pix_g = pix_r;
                pix_b = pix_r;
            end
            PAT_BARS: begin
                pix_r = {CW{bar_rgb[2]}};
                pix_g = {CW{bar_rgb[1]}};
                pix_b = {CW{bar_rgb[0]}};
            end
            PAT_CHECK: begin
                pix_r = {CW{!chk_black}};
                pix_g = {CW{!chk_black}};
                pix_b = {CW{!chk_black}};
            end
            default: begin
                pix_r = SOLID_RGB[3*CW-1:2*CW];
                pix_g = SOLID_RGB[2*CW-1:CW];
                pix_b = SOLID_RGB[CW-1:0];
            end
        endcase
        if (!tg_de) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    logic [CW-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic          hs_q, vs_q, de_q, fs_q, hs_d, vs_d, de_d, fs_d;

    // Output stage inputs: everything describes the same counter state.
    always_comb begin
        r_d  = pix_r;
        g_d  = pix_g;
        b_d  = pix_b;
        hs_d = tg_hs;
        vs_d = tg_vs;
        de_d = tg_de;
        fs_d = tg_first;
    end

    // Output register stage: one cycle behind the counters, all aligned.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= !HS_POL;
            vs_q <= !VS_POL;
            de_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            fs_q <= fs_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_DE      = de_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen with a small raster (24x8 total, 16x4 active).
// The reference tracks elapsed cycles since reset and derives position,
// frame number and expected pixel from plain arithmetic.
module tb_video_pattern_gen;

    localparam int CW   = 8;
    localparam int HA   = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA   = 4,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT   = HA + HFP + HSY + HBP;   // 24
    localparam int VT   = VA + VFP + VSY + VBP;   // 8
    localparam int FT   = HT * VT;                // 192
    localparam int CL   = 2;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [1:0]      MODE = 2'd0;
    logic [3*CW-1:0] SOLID_RGB = '0;
    logic [CW-1:0]   VGA_R, VGA_G, VGA_B;
    logic            VGA_HS, VGA_VS, VGA_DE, FRAME_START;

    video_pattern_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(CL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .SOLID_RGB(SOLID_RGB),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int t = 0;        // cycles of counter state since reset release
    int mode_m = 0;   // mode of the frame being produced

    // Expected {R,G,B} for an active pixel.
    function automatic logic [23:0] ref_pixel(int h, int v, int mode, int off,
                                              logic [23:0] solid);
        int bar;
        case (mode)
            0: return {3{8'((h + off) % 256)}};
            1: begin
                bar = h / (HA / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((h / (1 << CL)) % 2) ^ ((v / (1 << CL)) % 2)) == 0)
                      ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    // Apply one clock edge with the current inputs and check the outputs.
    task automatic tick(input string tag);
        logic [27:0] exp_v, obs_v;
        int h, v, off;
        logic de;
        if (!RST_N) begin
            exp_v = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            if (h == 0 && v == 0) mode_m = int'(MODE);
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
            off = (t / FT) % 256;
`else
            off = 0;
`endif
            de = (h < HA) && (v < VA);
            exp_v = {de ? ref_pixel(h, v, mode_m, off, SOLID_RGB) : 24'h0,
                     de,
                     !((h >= HA + HFP) && (h < HA + HFP + HSY)),
                     !((v >= VA + VFP) && (v < VA + VFP + VSY)),
                     (h == 0 && v == 0)};
        end
        @(posedge CLK);
        #1;
        obs_v = {VGA_R, VGA_G, VGA_B, VGA_DE, VGA_HS, VGA_VS, FRAME_START};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s t=%0d rgb/de/hs/vs/fs observed=%h expected=%h",
                   tag, t, obs_v, exp_v);
        end
        if (!RST_N) begin
            t = 0;
            mode_m = 0;
        end else begin
            t++;
        end
    endtask

    initial begin
        // Reset values
        RST_N = 1'b0;
        repeat (3) tick("reset");

        // Gradation from release: DE/HS/VS/FRAME_START cadence and ramp
        RST_N = 1'b1;
        MODE  = 2'd0;
        repeat (2 * FT) tick("grad");

        // Mode change mid-frame at h=5, v=2 only affects the next frame
        while ((t % FT) != 2 * HT + 5) tick("grad_pre");
        MODE      = 2'd3;
        SOLID_RGB = 24'h123456;
        repeat (FT - (2 * HT + 5)) tick("grad_tail");
        repeat (FT) tick("solid");

        // Colour bars
        MODE = 2'd1;
        repeat (2 * FT) tick("bars");

        // Checker
        MODE = 2'd2;
        repeat (2 * FT) tick("checker");

        // Reset mid-line on line 2 for 3 cycles
        while ((t % FT) != 2 * HT + 7) tick("checker_pre");
        RST_N = 1'b0;
        repeat (3) tick("mid_reset");
        RST_N = 1'b1;
        repeat (FT + 10) tick("post_reset");

        // Randomized: per-cycle SOLID_RGB, occasional mode changes and resets
        for (int i = 0; i < 4000; i++) begin
            SOLID_RGB = 24'($urandom);
            if ($urandom_range(0, 99) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                RST_N = 1'b0;
                repeat ($urandom_range(1, 4)) tick("rand_reset");
                RST_N = 1'b1;
            end
            tick("random");
        end

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
        // Scrolling gradation across the 256-frame wrap
        MODE  = 2'd0;
        RST_N = 1'b0;
        tick("scroll_reset");
        RST_N = 1'b1;
        repeat (257 * FT + 4) tick("scroll");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
